// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a UART transmitter through a
// request/busy handshake (S_IDLE -> S_REQ -> S_WAIT).
// Optional: define UART_TXQ_DROP_COUNT_EN to add the drop_count output, a
// saturating count of writes discarded because the queue was full.
module uart_tx_queue #(
   parameter int DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                wr_data,
   input  logic                      wr_en,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    level,
   output logic [7:0]                tx_byte,
   output logic                      send_request,
   input  logic                      busy
`ifdef UART_TXQ_DROP_COUNT_EN
   ,
   output logic [7:0]                drop_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_queue: DEPTH must be a power of two in 2..256");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t        state, state_next;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level_next;
   logic          push, pop, load;

   // full is the registered flag, so a pop on the same edge cannot make room
   assign push = wr_en && !full;

   // Storage: no reset, only written entries are ever read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // Level bookkeeping; simultaneous push and pop cancel out
   always_comb begin
      level_next = level;
      case ({push, pop})
         2'b10:   level_next = level + LW'(1);
         2'b01:   level_next = level - LW'(1);
         default: level_next = level;
      endcase
   end

   // Pointers and registered level/flags, all derived from level_next
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         level <= level_next;
         full  <= (level_next == LW'(DEPTH));
         empty <= (level_next == '0);
      end
   end

   // Handshake next-state: the head entry stays queued until the UART
   // has taken it (busy seen) and finished (busy dropped)
   always_comb begin
      state_next = state;
      load       = 1'b0;
      pop        = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!empty) begin
               load       = 1'b1;
               state_next = S_REQ;
            end
         end
         S_REQ: begin
            if (busy) state_next = S_WAIT;
         end
         S_WAIT: begin
            if (!busy) begin
               pop        = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // State register plus registered request and byte outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         send_request <= 1'b0;
         tx_byte      <= 8'h00;
      end else begin
         state        <= state_next;
         send_request <= (state_next == S_REQ);
         if (load) tx_byte <= mem[rd_ptr];
      end
   end

`ifdef UART_TXQ_DROP_COUNT_EN
   // Saturating count of writes refused because the queue was full
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_count <= 8'h00;
      else if (wr_en && full && drop_count != 8'hFF)
         drop_count <= drop_count + 8'h01;
   end
`endif

endmodule
